// File: rtl/p2s_pkg.sv
// Shared constants and FSM encoding for the p2s arbiter slice.
// Define P2S_PARITY_EN to add the PAR state (even-parity trailer bit).
package p2s_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 4;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OW_DEF = idx_width(NREQ_DEF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
`ifdef P2S_PARITY_EN
        ,
        S_PAR   = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/p2s_shift.sv
// Word shift register with bit counter; LSB leaves first.
// last is high while the final data bit is on bit_out.
module p2s_shift
    import p2s_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift_en,
    input  logic [DW-1:0] data,
    output logic          bit_out,
    output logic          last
);

    localparam int CW = idx_width(DW);

    logic [DW-1:0] sreg;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= data;
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= sreg >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

    assign bit_out = sreg[0];
    assign last    = (cnt == CW'(DW - 1));

endmodule

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter feeding one LSB-first serializer.
// Define P2S_PARITY_EN to append an even-parity bit to each frame.
module p2s_arbiter
    import p2s_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    parameter  int DW   = DW_DEF,
    localparam int OW   = idx_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    output logic [NREQ-1:0]    grant,
    output logic [OW-1:0]      owner,
    output logic               serial_out,
    output logic               valid_out,
    output logic               empty_out
);

    state_t        state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] pick;
    logic [DW-1:0] word;
    logic          arb;
    logic          sh_bit;
    logic          sh_last;
    int            j;

    // Scan farthest-first so the nearest requester from rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        j    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (req[j]) pick = OW'(j);
        end
    end

    assign word = data_in[int'(pick)*DW +: DW];

    // The gap's closing edge is also the first idle edge: frames run back to back.
    assign arb = ((state == S_IDLE) || (state == S_GAP)) && (|req);

    p2s_shift #(
        .DW(DW)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (arb),
        .shift_en(state == S_SHIFT),
        .data    (word),
        .bit_out (sh_bit),
        .last    (sh_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            valid_out <= 1'b0;
            empty_out <= 1'b1;
        end else begin
            grant <= '0;
            unique case (state)
                S_IDLE, S_GAP: begin
                    if (|req) begin
                        state     <= S_SHIFT;
                        grant     <= NREQ'(1) << pick;
                        owner     <= pick;
                        rr_ptr    <= (int'(pick) == NREQ - 1) ? '0 : pick + OW'(1);
                        valid_out <= 1'b1;
                        empty_out <= 1'b0;
                    end else begin
                        state     <= S_IDLE;
                        valid_out <= 1'b0;
                        empty_out <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (sh_last) begin
`ifdef P2S_PARITY_EN
                        state <= S_PAR;
`else
                        state     <= S_GAP;
                        valid_out <= 1'b0;
`endif
                    end
                end
`ifdef P2S_PARITY_EN
                S_PAR: begin
                    state     <= S_GAP;
                    valid_out <= 1'b0;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef P2S_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst)      par_q <= 1'b0;
        else if (arb) par_q <= ^word;
    end
`endif

    always_comb begin
        serial_out = 1'b0;
        if (state == S_SHIFT) serial_out = sh_bit;
`ifdef P2S_PARITY_EN
        if (state == S_PAR) serial_out = par_q;
`endif
    end

endmodule
